tge_tx_status_collector: RTL and testbench

TGE_TX_STATUS_COLLECTOR -- requirements
Module: tge_tx_status_collector

---
 rtl/tge_tx_status_collector_pkg.sv | 26 ++
 rtl/tge_sat_counter.sv | 29 ++
 rtl/tge_tx_status_collector.sv | 145 ++++++++++++++
 tb/tb_tge_tx_status_collector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tge_tx_status_collector_pkg.sv
// Shared types and constants for the 10GbE TX status collector.
// Field positions describe the packed software status word.
package tge_tx_status_collector_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } frame_st_e;

  localparam int BIT_LINK     = 31;
  localparam int BIT_OVF_ST   = 30;
  localparam int BIT_AFULL    = 29;
  localparam int BIT_AFULL_ST = 28;
  localparam int ABORT_LSB    = 24;
  localparam int OVF_LSB      = 16;
  localparam int FRAME_LSB    = 0;

  localparam int FRAME_W = 16;
  localparam int OVF_W   = 8;
  localparam int ABORT_W = 4;

  localparam logic [OVF_W-1:0]   OVF_MAX   = 8'hFF;
  localparam logic [ABORT_W-1:0] ABORT_MAX = 4'hF;
  localparam logic [FRAME_W-1:0] FRAME_MAX = 16'hFFFF;

endpackage

// File: rtl/tge_sat_counter.sv
// Event counter with synchronous clear; saturates at MAX or wraps.
// Reset outranks clear, clear outranks increment.
module tge_sat_counter #(
  parameter int           W   = 8,
  parameter bit           SAT = 1'b1,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = SAT && (cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tge_tx_status_collector.sv
// Collects 10GbE TX frame, overflow and abort statistics
// into one registered status word for software.
module tge_tx_status_collector
  import tge_tx_status_collector_pkg::*;
#(
  parameter bit ABORT_ON_LINK_DOWN = 1'b1
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        tx_valid,
  input  logic        tx_end_of_frame,
  input  logic        tx_overflow,
  input  logic        tx_afull,
  input  logic        link_up,
  input  logic        status_clr,
  output logic [31:0] status_out
);

  frame_st_e st;

  logic link_q;
  logic afull_q;
  logic ovf_q;
  logic ovf_st;
  logic afull_st;
  logic frame_inc;
  logic abort_inc;
  logic ovf_rise;
  logic eof_beat;

  logic [FRAME_W-1:0] frame_cnt;
  logic [OVF_W-1:0]   ovf_cnt;
  logic [ABORT_W-1:0] abort_cnt;

  assign eof_beat = tx_valid & tx_end_of_frame;
  assign ovf_rise = tx_overflow & ~ovf_q;

  // A link drop inside a frame wins over a same-cycle EOF.
  always_comb begin
    frame_inc = 1'b0;
    abort_inc = 1'b0;
    unique case (st)
      ST_IDLE: begin
        frame_inc = link_up & eof_beat;
      end
      ST_IN_FRAME: begin
        if (!link_up) begin
          abort_inc = ABORT_ON_LINK_DOWN;
        end else begin
          frame_inc = eof_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      st <= ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (link_up && tx_valid && !tx_end_of_frame) begin
            st <= ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (!link_up || eof_beat) begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      link_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovf_st   <= 1'b0;
      afull_st <= 1'b0;
    end else begin
      link_q  <= link_up;
      afull_q <= tx_afull;
      ovf_q   <= tx_overflow;
      if (status_clr) begin
        ovf_st   <= 1'b0;
        afull_st <= 1'b0;
      end else begin
        ovf_st   <= ovf_st | tx_overflow;
        afull_st <= afull_st | tx_afull;
      end
    end
  end

  tge_sat_counter #(
    .W   (FRAME_W),
    .SAT (1'b0),
    .MAX (FRAME_MAX)
  ) u_frame_cnt (
    .clk (user_clk),
    .rst (user_rst),
    .clr (status_clr),
    .inc (frame_inc),
    .cnt (frame_cnt)
  );

  tge_sat_counter #(
    .W   (OVF_W),
    .SAT (1'b1),
    .MAX (OVF_MAX)
  ) u_ovf_cnt (
    .clk (user_clk),
    .rst (user_rst),
    .clr (status_clr),
    .inc (ovf_rise),
    .cnt (ovf_cnt)
  );

  tge_sat_counter #(
    .W   (ABORT_W),
    .SAT (1'b1),
    .MAX (ABORT_MAX)
  ) u_abort_cnt (
    .clk (user_clk),
    .rst (user_rst),
    .clr (status_clr),
    .inc (abort_inc),
    .cnt (abort_cnt)
  );

  always_comb begin
    status_out = '0;
    status_out[BIT_LINK]     = link_q;
    status_out[BIT_OVF_ST]   = ovf_st;
    status_out[BIT_AFULL]    = afull_q;
    status_out[BIT_AFULL_ST] = afull_st;
    status_out[ABORT_LSB +: ABORT_W] = abort_cnt;
    status_out[OVF_LSB +: OVF_W]     = ovf_cnt;
    status_out[FRAME_LSB +: FRAME_W] = frame_cnt;
  end

endmodule

// File: tb/tb_tge_tx_status_collector.sv
// Bench for the TX status collector: behavioural model,
// per-cycle compare, directed scenarios and random traffic.
module tb_tge_tx_status_collector;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic        tx_overflow;
  logic        tx_afull;
  logic        link_up;
  logic        status_clr;
  logic [31:0] status_a;
  logic [31:0] status_b;

  int tests = 0;
  int fails = 0;

  tge_tx_status_collector #(
    .ABORT_ON_LINK_DOWN (1'b1)
  ) dut_a (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .tx_valid        (tx_valid),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_overflow     (tx_overflow),
    .tx_afull        (tx_afull),
    .link_up         (link_up),
    .status_clr      (status_clr),
    .status_out      (status_a)
  );

  tge_tx_status_collector #(
    .ABORT_ON_LINK_DOWN (1'b0)
  ) dut_b (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .tx_valid        (tx_valid),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_overflow     (tx_overflow),
    .tx_afull        (tx_afull),
    .link_up         (link_up),
    .status_clr      (status_clr),
    .status_out      (status_b)
  );

  always #5 user_clk = ~user_clk;

  // Reference model state
  bit m_ok = 1'b0;
  bit m_in_frame;
  bit m_prev_ovf;
  bit m_link;
  bit m_afull;
  bit m_ovf_st;
  bit m_afull_st;
  int m_frames;
  int m_ovf_ev;
  int m_aborts;
  bit m_rise;
  bit m_done;
  bit m_abort;

  always @(posedge user_clk) begin
    if (user_rst) begin
      m_ok       = 1'b1;
      m_in_frame = 1'b0;
      m_prev_ovf = 1'b0;
      m_link     = 1'b0;
      m_afull    = 1'b0;
      m_ovf_st   = 1'b0;
      m_afull_st = 1'b0;
      m_frames   = 0;
      m_ovf_ev   = 0;
      m_aborts   = 0;
    end else begin
      m_rise     = tx_overflow && !m_prev_ovf;
      m_prev_ovf = tx_overflow;
      m_link     = link_up;
      m_afull    = tx_afull;
      m_done     = 1'b0;
      m_abort    = 1'b0;
      if (m_in_frame) begin
        if (!link_up) begin
          m_abort    = 1'b1;
          m_in_frame = 1'b0;
        end else if (tx_valid && tx_end_of_frame) begin
          m_done     = 1'b1;
          m_in_frame = 1'b0;
        end
      end else if (link_up && tx_valid) begin
        if (tx_end_of_frame) m_done = 1'b1;
        else m_in_frame = 1'b1;
      end
      if (status_clr) begin
        m_frames   = 0;
        m_ovf_ev   = 0;
        m_aborts   = 0;
        m_ovf_st   = 1'b0;
        m_afull_st = 1'b0;
      end else begin
        if (m_done) m_frames = (m_frames + 1) % 65536;
        if (m_rise && m_ovf_ev < 255) m_ovf_ev++;
        if (m_abort && m_aborts < 15) m_aborts++;
        if (tx_overflow) m_ovf_st = 1'b1;
        if (tx_afull) m_afull_st = 1'b1;
      end
    end
  end

  function automatic logic [31:0] expect_word(bit with_abort);
    logic [3:0]  ab;
    logic [7:0]  ov;
    logic [15:0] fr;
    ab = with_abort ? m_aborts[3:0] : 4'h0;
    ov = m_ovf_ev[7:0];
    fr = m_frames[15:0];
    return {m_link, m_ovf_st, m_afull, m_afull_st, ab, ov, fr};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t",
               name, got, want, $time);
    end
  endtask

  always @(negedge user_clk) begin
    if (m_ok) begin
      check("cycle_abort1", status_a, expect_word(1'b1));
      check("cycle_abort0", status_b, expect_word(1'b0));
    end
  end

  task automatic tick();
    @(negedge user_clk);
  endtask

  initial begin
    user_rst        = 1'b1;
    tx_valid        = 1'b0;
    tx_end_of_frame = 1'b0;
    tx_overflow     = 1'b0;
    tx_afull        = 1'b0;
    link_up         = 1'b1;
    status_clr      = 1'b0;
    tick();
    tick();
    check("reset", status_a, 32'h0000_0000);
    user_rst = 1'b0;

    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        tx_valid        = 1'b1;
        tx_end_of_frame = (b == 3);
        tick();
      end
    end
    tx_valid        = 1'b0;
    tx_end_of_frame = 1'b0;
    check("three_frames", status_a, 32'h8000_0003);

    tx_valid        = 1'b1;
    tx_end_of_frame = 1'b1;
    tick();
    tx_valid        = 1'b0;
    tx_end_of_frame = 1'b0;
    link_up         = 1'b0;
    tick();
    link_up = 1'b1;
    tick();
    check("single_beat_idle", status_a, 32'h8000_0004);

    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    tx_overflow = 1'b1;
    repeat (10) tick();
    tx_overflow = 1'b0;
    tick();
    repeat (3) begin
      tx_overflow = 1'b1;
      tick();
      tx_overflow = 1'b0;
      tick();
    end
    check("ovf_four", status_a & 32'h40FF_0000, 32'h4004_0000);
    repeat (300) begin
      tx_overflow = 1'b1;
      tick();
      tx_overflow = 1'b0;
      tick();
    end
    check("ovf_sat", status_a & 32'h00FF_0000, 32'h00FF_0000);

    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    repeat (20) begin
      tx_valid        = 1'b1;
      tx_end_of_frame = 1'b0;
      link_up         = 1'b1;
      tick();
      link_up = 1'b0;
      tick();
      tick();
      tx_end_of_frame = 1'b1;
      tick();
      tx_valid        = 1'b0;
      tx_end_of_frame = 1'b0;
      link_up         = 1'b1;
      tick();
    end
    check("abort_sat", status_a & 32'h0F00_FFFF, 32'h0F00_0000);
    check("abort_off", status_b & 32'h0F00_FFFF, 32'h0000_0000);

    tx_afull        = 1'b1;
    tx_valid        = 1'b1;
    tx_end_of_frame = 1'b0;
    tick();
    tx_end_of_frame = 1'b1;
    status_clr      = 1'b1;
    tick();
    status_clr      = 1'b0;
    tx_valid        = 1'b0;
    tx_end_of_frame = 1'b0;
    check("clr_vs_eof", status_a & 32'hB000_FFFF, 32'hA000_0000);
    tx_afull = 1'b0;
    tick();

    status_clr = 1'b1;
    tick();
    status_clr      = 1'b0;
    tx_valid        = 1'b1;
    tx_end_of_frame = 1'b1;
    repeat (65536) tick();
    check("frame_wrap", status_a & 32'h0000_FFFF, 32'h0000_0000);
    tick();
    check("frame_wrap_plus1", status_a & 32'h0000_FFFF, 32'h0000_0001);
    tx_valid        = 1'b0;
    tx_end_of_frame = 1'b0;

    repeat (4000) begin
      tx_valid        = ($urandom_range(0, 3) != 0);
      tx_end_of_frame = ($urandom_range(0, 3) == 0);
      tx_overflow     = ($urandom_range(0, 7) == 0) ? ~tx_overflow
                                                    : tx_overflow;
      tx_afull        = ($urandom_range(0, 15) == 0);
      link_up         = ($urandom_range(0, 11) != 0);
      status_clr      = ($urandom_range(0, 63) == 0);
      user_rst        = ($urandom_range(0, 255) == 0);
      tick();
    end
    user_rst = 1'b1;
    tick();
    user_rst = 1'b0;
    check("final_reset", status_a, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
